// File: rtl/axi_lite_pkg.sv
// Shared types and defaults for the two-requester AXI-Lite arbiter.
package axi_lite_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Round-robin pick: a lone requester wins; on a tie the one that did not win last time goes.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
    if (req == 2'b11) return ~last_owner;
    return req[1];
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// Bundle of requester-side and downstream-side signals around the arbiter.
// slave: the arbiter's view. master: the environment (requesters + downstream port).
interface axi_lite_arbiter_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [1:0]             s_transfer;
  logic [1:0]             s_write;
  logic [1:0][ADDR_W-1:0] s_addr;
  logic [1:0][DATA_W-1:0] s_wdata;
  logic [1:0]             s_ready;
  logic [1:0][DATA_W-1:0] s_rdata;

  logic                   m_transfer;
  logic                   m_write;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic                   m_ready;
  logic [DATA_W-1:0]      m_rdata;

  logic [1:0]             gnt;

  modport slave (
    input  s_transfer, s_write, s_addr, s_wdata, m_ready, m_rdata,
    output s_ready, s_rdata, m_transfer, m_write, m_addr, m_wdata, gnt
  );

  modport master (
    output s_transfer, s_write, s_addr, s_wdata, m_ready, m_rdata,
    input  s_ready, s_rdata, m_transfer, m_write, m_addr, m_wdata, gnt
  );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI-Lite master command port.
// State | meaning
// IDLE    | no owner, waiting for any request
// BUSY    | owner's command driven downstream, waiting for m_ready
// RELEASE | transaction done, waiting for owner to drop its request
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              ACLK,
  input logic              ARESETn,
  axi_lite_arbiter_if.slave bus
);

  arb_state_e             state_q;
  logic                   owner_q;
  logic                   last_owner_q;
  logic [1:0]             gnt_q;
  logic                   m_transfer_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   pick;

  assign pick = rr_pick(bus.s_transfer, last_owner_q);

  // Arbitration FSM; grant, request-out and held read data are all registered here.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      m_transfer_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.s_transfer) begin
            state_q      <= ST_BUSY;
            owner_q      <= pick;
            last_owner_q <= pick;
            gnt_q        <= pick ? 2'b10 : 2'b01;
            m_transfer_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.m_ready) begin
            state_q      <= ST_RELEASE;
            m_transfer_q <= 1'b0;
            if (!bus.s_write[owner_q]) rdata_q[owner_q] <= bus.m_rdata;
          end
        end
        ST_RELEASE: begin
          // Waiting for the drop stops a still-held request from being issued twice.
          if (!bus.s_transfer[owner_q]) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Downstream command muxed live from the owner so late write data is forwarded.
  always_comb begin
    bus.m_write = 1'b0;
    bus.m_addr  = {ADDR_W{1'b0}};
    bus.m_wdata = {DATA_W{1'b0}};
    bus.s_ready = 2'b00;
    if (m_transfer_q) begin
      bus.m_write          = bus.s_write[owner_q];
      bus.m_addr           = bus.s_addr[owner_q];
      bus.m_wdata          = bus.s_wdata[owner_q];
      // Gated by reset so a completion racing a reset is never reported upstream.
      bus.s_ready[owner_q] = bus.m_ready & ARESETn;
    end
  end

  assign bus.m_transfer = m_transfer_q;
  assign bus.gnt        = gnt_q;
  assign bus.s_rdata    = rdata_q;

endmodule
